// File: rtl/hazard_scoreboard.sv
// Scoreboard-driven stall/forward unit: tracks in-flight register writers across DEPTH post-decode slots
// and owns the multiply/divide busy counter that gates HI/LO accesses.
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int TW      = 3,
    parameter int DEPTH   = 3,
    parameter int SW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          D_valid,
    input  logic [AW-1:0] D_rs,
    input  logic [AW-1:0] D_rt,
    input  logic          D_use_rs,
    input  logic          D_use_rt,
    input  logic [TW-1:0] D_tuse_rs,
    input  logic [TW-1:0] D_tuse_rt,
    input  logic [AW-1:0] D_dst,
    input  logic [TW-1:0] D_tnew,
    input  logic          D_md_start,
    input  logic          D_md_div,
    input  logic          D_hilo_use,
    output logic          Stall,
    output logic [SW-1:0] Fsel_rs_D,
    output logic [SW-1:0] Fsel_rt_D,
    output logic [SW-1:0] Fsel_rs_E,
    output logic [SW-1:0] Fsel_rt_E,
    output logic          MD_busy
);

    localparam int CW = $clog2(DIV_LAT + 1);

    logic [DEPTH:1]  slot_valid;
    logic [AW-1:0]   slot_dst  [1:DEPTH];
    logic [TW-1:0]   slot_tnew [1:DEPTH];
    logic [AW-1:0]   e_rs, e_rt;
    logic            e_use_rs, e_use_rt;
    logic [CW-1:0]   md_count;
    logic            issue;

    logic            rs_hit, rt_hit, ers_hit, ert_hit;
    logic [SW-1:0]   rs_idx, rt_idx, ers_idx, ert_idx;
    logic [TW-1:0]   rs_tnew, rt_tnew, ers_tnew, ert_tnew;
    logic            stall_rs, stall_rt, stall_hilo;

    // Scans from the oldest slot down so the nearest (smallest k) match overwrites older ones.
    function automatic void lookup(input logic [AW-1:0] r, input int first,
                                   output logic hit, output logic [SW-1:0] idx,
                                   output logic [TW-1:0] tn);
        hit = 1'b0;
        idx = '0;
        tn  = '0;
        for (int k = DEPTH; k >= first; k--) begin
            if (slot_valid[k] && slot_dst[k] == r && r != '0) begin
                hit = 1'b1;
                idx = SW'(k);
                tn  = slot_tnew[k];
            end
        end
    endfunction

    always_comb begin
        lookup(D_rs, 1, rs_hit, rs_idx, rs_tnew);
        lookup(D_rt, 1, rt_hit, rt_idx, rt_tnew);
        lookup(e_rs, 2, ers_hit, ers_idx, ers_tnew);
        lookup(e_rt, 2, ert_hit, ert_idx, ert_tnew);

        stall_rs   = D_valid && D_use_rs && rs_hit && (rs_tnew > D_tuse_rs);
        stall_rt   = D_valid && D_use_rt && rt_hit && (rt_tnew > D_tuse_rt);
        stall_hilo = D_valid && D_hilo_use && MD_busy;
        Stall      = stall_rs || stall_rt || stall_hilo;

        Fsel_rs_D = (rs_hit && rs_tnew == '0) ? rs_idx : '0;
        Fsel_rt_D = (rt_hit && rt_tnew == '0) ? rt_idx : '0;
        Fsel_rs_E = (slot_valid[1] && e_use_rs && ers_hit && ers_tnew == '0) ? ers_idx : '0;
        Fsel_rt_E = (slot_valid[1] && e_use_rt && ert_hit && ert_tnew == '0) ? ert_idx : '0;
    end

    assign issue   = D_valid && !Stall;
    assign MD_busy = (md_count != '0);

    // Slot 1 captures the issuing instruction (or a bubble); older slots shift with tnew counting down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                slot_dst[k]  <= '0;
                slot_tnew[k] <= '0;
            end
            e_rs     <= '0;
            e_rt     <= '0;
            e_use_rs <= 1'b0;
            e_use_rt <= 1'b0;
        end else begin
            slot_valid[1] <= issue;
            slot_dst[1]   <= D_dst;
            slot_tnew[1]  <= D_tnew;
            e_rs          <= D_rs;
            e_rt          <= D_rt;
            e_use_rs      <= D_use_rs;
            e_use_rt      <= D_use_rt;
            for (int k = 2; k <= DEPTH; k++) begin
                slot_valid[k] <= slot_valid[k-1];
                slot_dst[k]   <= slot_dst[k-1];
                slot_tnew[k]  <= (slot_tnew[k-1] != '0) ? slot_tnew[k-1] - TW'(1) : '0;
            end
        end
    end

    // A new mult/div only issues once the counter is idle, because it also counts as a HI/LO user.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_count <= '0;
        end else if (issue && D_md_start) begin
            md_count <= D_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (md_count != '0) begin
            md_count <= md_count - CW'(1);
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage stall/forward unit.
- Tracks in-flight register writers in a shift-register scoreboard of DEPTH post-decode slots (slot 1 = E, slot 2 = M, ..., slot DEPTH = W).
- Generates D-stage stall and D/E-stage forward selects from per-instruction Tuse/Tnew, independent of opcode decoding.
- Owns the multiply/divide busy counter that drives HI/LO stalls.

Parameters:
AW, 5, register address width (2^AW architectural registers, register 0 never tracked)
TW, 3, width of Tuse/Tnew fields
DEPTH, 3, number of post-D pipeline slots tracked (>=2)
SW, 2, forward-select width, must satisfy 2^SW > DEPTH
MUL_LAT, 5, busy cycles for a multiply
DIV_LAT, 10, busy cycles for a divide

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
D_valid  in  1  D holds a real instruction
D_rs  in  AW  D source register 1
D_rt  in  AW  D source register 2
D_use_rs  in  1  D reads rs
D_use_rt  in  1  D reads rt
D_tuse_rs  in  TW  cycles until rs is needed (0 = in D)
D_tuse_rt  in  TW  cycles until rt is needed
D_dst  in  AW  D destination register (0 = none)
D_tnew  in  TW  producer latency measured while in E (ALU 1, load 2, link 0)
D_md_start  in  1  D is mult/div
D_md_div  in  1  1 = divide, 0 = multiply
D_hilo_use  in  1  D touches HI/LO (includes mult/div, mfhi, mthi, ...)
Stall  out  1  freeze PC and F/D, insert bubble into E
Fsel_rs_D  out  SW  0 = regfile, k = slot k
Fsel_rt_D  out  SW  same, for rt
Fsel_rs_E  out  SW  forward select for the E instruction's rs (0 or 2..DEPTH)
Fsel_rt_E  out  SW  same, for rt
MD_busy  out  1  multiply/divide in progress

Behaviour:
- Slot k holds: valid, dst, tnew. Slot 1 additionally holds rs, rt, use_rs, use_rt.
- Issue = D_valid & !Stall.
- Every posedge:
  - slot1 <= issue ? {1, D_dst, D_tnew, D_rs, D_rt, D_use_rs, D_use_rt} : bubble (valid 0).
  - slot k <= slot k-1 for k >= 2, with tnew decremented and saturating at 0.
  - Slot DEPTH contents are discarded on the next edge; the regfile is written at that point.
- Match(k, r) = slot k valid & dst == r & r != 0.
- Nearest producer = smallest k with a match; older matches are shadowed.
- Stall, hazard part: for rs (and likewise rt), D_valid & use & nearest producer exists & its tnew > tuse.
- Stall, HI/LO part: D_valid & D_hilo_use & MD_busy.
- Stall is purely combinational from current state and D inputs.
- Fsel_*_D = k of the nearest producer if its tnew == 0, else 0. A later-forwarded or stalled case needs no D forward. Fsel is valid even when Stall = 1; the consumer ignores it.
- Fsel_*_E: the same rule applied to slot 1's rs/rt over slots 2..DEPTH. Returns 0 if slot 1 is invalid or the use bit is clear.
- MD counter, width clog2(DIV_LAT+1):
  - On issue with D_md_start, load D_md_div ? DIV_LAT : MUL_LAT.
  - Otherwise decrement when nonzero.
  - MD_busy = counter != 0.
  - A mult/div that itself has D_hilo_use stalls while busy, so a new load never overlaps a running operation.
- Reset (asynchronous, any time, including mid-divide): all slot valid bits 0, counter 0. Stall, all Fsel and MD_busy read 0 immediately.
- Simultaneous events:
  - Stall and an older slot reaching tnew 0 on the same edge: stall drops the following cycle with no extra bubble.
  - Several matching slots: the nearest wins.
  - D_dst == D_rs on a single instruction: no self-hazard, since the scoreboard only compares against older slots.

Test Plan:
- ALU r8 (tnew 1) immediately followed by beq r8 (tuse_rs 0) -> Stall 1 one cycle, then Fsel_rs_D = 2; no stall for addu r9,r8 (tuse 1), Fsel_rs_E = 2 next cycle.
- lw r5 (tnew 2), then addu r6,r5,r0 (tuse 1) -> exactly one stall cycle, then Fsel_rs_E = 3 (W, DEPTH=3).
- lw r5, addu r5,..., addu r7,r5 -> Fsel_rs_E = 2 (nearest producer), not 3.
- D_dst = 0 producer followed by a reader of r0 -> Stall 0, all Fsel 0.
- div issued, mfhi next -> Stall held exactly 10 cycles, MD_busy falls on the same edge, mfhi issues the next cycle; repeat with mult -> 5 cycles.
- Assert reset 3 cycles into a divide while a load is in slot 1 -> MD_busy, Stall and Fsel go to 0 without waiting for clk; first post-reset instruction issues with no stall.
